// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-refill memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned LINE_OFF_W = 4;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 128;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [LINE_W_DEF-1:0] line_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin sharing of one line-refill memory port; one outstanding transaction.
// Optional watchdog in REQ enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [LINE_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ready,
    input  logic [LINE_W-1:0]         mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  data_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;
    logic               capture;
    logic               timeout_c;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  aligned_addr;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign sel_addr     = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    assign aligned_addr = sel_addr & ~ADDR_W'(LINE_BYTES - 1);

    // Next-state and handshake decode
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = grant;
                if (grant_any) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    capture = 1'b1;
                    state_d = RSP;
                end else if (timeout_c) begin
                    state_d = RSP;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory/response outputs decoded straight from the state register
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        rsp_valid = '0;
        if (state_q == REQ) begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
        end
        if (state_q == RSP) begin
            rsp_valid = NUM_REQ'(1) << idx_q;
        end
    end

    assign rsp_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q    <= grant_idx;
                addr_q   <= aligned_addr;
                rr_ptr_q <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
            end
            if (capture) begin
                data_q <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    assign timeout_c = (state_q == REQ) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = (state_q == RSP) && err_q;

    // Counter is zero on entry to REQ and counts REQ cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                wdog_q <= wdog_q + WD_W'(1);
                if (mem_ready) begin
                    err_q <= 1'b0;
                end else if (timeout_c) begin
                    err_q <= 1'b1;
                end
            end else begin
                wdog_q <= '0;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: table of single transactions plus hand-written corner cases.
module tb_mem_refill_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [63:0]  req_addr;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mem_refill_arbiter #(
        .NUM_REQ(2), .ADDR_W(32), .LINE_W(128), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic [1:0]   valid;
        logic [31:0]  a0;
        logic [31:0]  a1;
        int           k;
        logic [127:0] data;
        logic [1:0]   exp_grant;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        req_valid = v.valid;
        req_addr  = {v.a1, v.a0};
        #1;
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(v.exp_grant));
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= v.k; c++) begin
            chk({tag, "_mem_req"}, 128'(mem_req), 128'(1'b1));
            chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(v.exp_addr));
            chk({tag, "_no_ready_in_req"}, 128'(req_ready), 128'(2'b00));
            if (c == v.k) begin
                mem_ready = 1'b1;
                mem_rdata = v.data;
            end
            tick();
            mem_ready = 1'b0;
            mem_rdata = '0;
        end
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(v.exp_grant));
        chk({tag, "_rsp_data"}, rsp_data, v.data);
        chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(1'b0));
        chk({tag, "_mem_idle_in_rsp"}, 128'({mem_req, mem_addr}), 128'(0));
        tick();
        chk({tag, "_rsp_one_cycle"}, 128'(rsp_valid), 128'(2'b00));
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'h1234_5678, 32'h0,         3, {16{8'hA5}},     2'b01, 32'h1234_5670};
        vecs[1] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_100F, 2, {4{32'h1111_0001}}, 2'b10, 32'h0000_1000};
        vecs[2] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_100F, 2, {4{32'h2222_0002}}, 2'b01, 32'hDEAD_BEE0};
        vecs[3] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_100F, 4, {4{32'h3333_0003}}, 2'b10, 32'h0000_1000};
        vecs[4] = '{2'b11, 32'hCAFE_0019, 32'h0000_2024, 1, {4{32'h4444_0004}}, 2'b01, 32'hCAFE_0010};
        vecs[5] = '{2'b01, 32'h8000_000F, 32'h0000_2024, 1, {4{32'h5555_0005}}, 2'b01, 32'h8000_0000};
        vecs[6] = '{2'b10, 32'h8000_000F, 32'hFFFF_FFFF, 2, {4{32'h6666_0006}}, 2'b10, 32'hFFFF_FFF0};
        vecs[7] = '{2'b10, 32'h8000_000F, 32'h0000_0010, 1, {4{32'h7777_0007}}, 2'b10, 32'h0000_0010};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", rsp_data, 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 128'({req_ready, mem_req}), 128'(0));

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Stray mem_ready while IDLE: ignored
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stray_idle_rsp_valid", 128'(rsp_valid), 128'(0));
            chk("stray_idle_rsp_data", rsp_data, vecs[7].data);
            chk("stray_idle_mem_req", 128'(mem_req), 128'(0));
        end
        mem_ready = 1'b0;

        // Stray mem_ready held through RSP: only the REQ-cycle data is captured
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h0000_0044};
        #1;
        chk("stray_grant", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b1;
        mem_rdata = {4{32'h0D1D_0D1D}};
        tick();
        mem_rdata = {4{32'h0D2D_0D2D}};
        chk("stray_rsp_valid", 128'(rsp_valid), 128'(2'b01));
        chk("stray_rsp_data", rsp_data, {4{32'h0D1D_0D1D}});
        tick();
        chk("stray_after_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("stray_after_rsp_data", rsp_data, {4{32'h0D1D_0D1D}});
        chk("stray_after_mem_req", 128'(mem_req), 128'(0));
        tick();
        chk("stray_idle2_state", 128'({rsp_valid, mem_req}), 128'(0));
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset asserted mid-REQ: outputs clear without a clock edge
        req_valid = 2'b10;
        req_addr  = {32'h0000_ABCD, 32'h0};
        #1;
        chk("rstmid_grant", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = 2'b00;
        chk("rstmid_mem_req", 128'(mem_req), 128'(1));
        chk("rstmid_mem_addr", 128'(mem_addr), 128'(32'h0000_ABC0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_mem_req", 128'(mem_req), 128'(0));
        chk("rstmid_async_mem_addr", 128'(mem_addr), 128'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = {4{32'hEEEE_EEEE}};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_rsp", 128'({rsp_valid, mem_req}), 128'(0));
            chk("rstmid_data_clear", rsp_data, 128'(0));
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        req_valid = 2'b11;
        #1;
        chk("rstmid_ptr_reset", 128'(req_ready), 128'(2'b01));
        req_valid = 2'b00;
        #1;
        tick();

        // No mem_ready at all: watchdog abort or indefinite wait
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h0000_0F0F};
        tick();
        req_valid = 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            chk("wdog_mem_req", 128'({mem_req, rsp_valid}), 128'(3'b100));
            tick();
        end
        chk("wdog_rsp_valid", 128'(rsp_valid), 128'(2'b01));
        chk("wdog_rsp_err", 128'(rsp_err), 128'(1));
        chk("wdog_rsp_data", rsp_data, 128'(0));
        chk("wdog_mem_req_low", 128'(mem_req), 128'(0));
        tick();
        chk("wdog_after", 128'({rsp_valid, rsp_err}), 128'(0));
`else
        for (int c = 1; c <= 100; c++) begin
            chk("hang_mem_req", 128'({mem_req, rsp_valid, rsp_err}), 128'(4'b1000));
            tick();
        end
        chk("hang_mem_addr", 128'(mem_addr), 128'(32'h0000_0F00));
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
